// File: rtl/foc_transform_seq.sv
// Per-PWM-period FOC sequencer: Park -> PI -> inverse Park, then commits alpha/beta.
// Define FOC_SEQ_LATENCY_EN to add the last_latency (trig-to-valid cycle count) output.
module foc_transform_seq #(
   parameter int D_WIDTH        = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               enable,
   input  logic               trig,
   output logic               park_start,
   input  logic               park_done,
   output logic               pi_start,
   input  logic               pi_done,
   output logic               ipark_start,
   input  logic               ipark_done,
   input  logic [D_WIDTH-1:0] alpha_in,
   input  logic [D_WIDTH-1:0] beta_in,
   output logic [D_WIDTH-1:0] alpha_out,
   output logic [D_WIDTH-1:0] beta_out,
   output logic               valid,
   output logic               busy,
   output logic               overrun,
   output logic               timeout_err,
`ifdef FOC_SEQ_LATENCY_EN
   output logic [15:0]        last_latency,
`endif
   input  logic               clr_err
);

   localparam int            CW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_PARK, S_PI, S_IPARK, S_COMMIT} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          stage_done;
   logic          accept, commit, ov_set, to_set;
   logic          park_start_nx, pi_start_nx, ipark_start_nx, busy_nx;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nx       = state;
      cnt_nx         = '0;
      accept         = 1'b0;
      commit         = 1'b0;
      ov_set         = 1'b0;
      to_set         = 1'b0;
      park_start_nx  = 1'b0;
      pi_start_nx    = 1'b0;
      ipark_start_nx = 1'b0;
      stage_done     = 1'b0;

      case (state)
         S_PARK:  stage_done = park_done;
         S_PI:    stage_done = pi_done;
         S_IPARK: stage_done = ipark_done;
         default: stage_done = 1'b0;
      endcase

      case (state)
         S_IDLE: begin
            if (trig && enable) begin
               accept        = 1'b1;
               state_nx      = S_PARK;
               park_start_nx = 1'b1;
            end
         end
         S_PARK, S_PI, S_IPARK: begin
            ov_set = trig;
            cnt_nx = cnt + CW'(1);
            if (!enable) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            // cnt==0 is the start-pulse cycle; done only counts from the cycle after it
            end else if (stage_done && cnt != '0) begin
               cnt_nx = '0;
               case (state)
                  S_PARK: begin
                     state_nx    = S_PI;
                     pi_start_nx = 1'b1;
                  end
                  S_PI: begin
                     state_nx       = S_IPARK;
                     ipark_start_nx = 1'b1;
                  end
                  default: begin
                     state_nx = S_COMMIT;
                     commit   = 1'b1;
                  end
               endcase
            end else if (cnt == TMO) begin
               state_nx = S_IDLE;
               to_set   = 1'b1;
               cnt_nx   = '0;
            end
         end
         S_COMMIT: begin
            // The valid cycle still counts as busy, so a trigger here is an overrun.
            ov_set   = trig;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase

      busy_nx = (state_nx == S_PARK) || (state_nx == S_PI) || (state_nx == S_IPARK);
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         park_start  <= 1'b0;
         pi_start    <= 1'b0;
         ipark_start <= 1'b0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         timeout_err <= 1'b0;
         alpha_out   <= '0;
         beta_out    <= '0;
      end else begin
         park_start  <= park_start_nx;
         pi_start    <= pi_start_nx;
         ipark_start <= ipark_start_nx;
         valid       <= commit;
         busy        <= busy_nx;
         // A set on the same edge as clr_err wins.
         overrun     <= ov_set | (overrun & ~clr_err);
         timeout_err <= to_set | (timeout_err & ~clr_err);
         if (commit) begin
            alpha_out <= alpha_in;
            beta_out  <= beta_in;
         end
      end
   end

`ifdef FOC_SEQ_LATENCY_EN
   logic [15:0] lat_cnt;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         lat_cnt      <= '0;
         last_latency <= '0;
      end else begin
         if (accept) begin
            lat_cnt <= 16'd1;
         end else if (lat_cnt != 16'hFFFF) begin
            lat_cnt <= lat_cnt + 16'd1;
         end
         // The commit edge closes the valid cycle, hence one more than the running count.
         if (commit) begin
            last_latency <= (lat_cnt == 16'hFFFF) ? 16'hFFFF : lat_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/foc_transform_seq.md
Name: foc_transform_seq

Overview:
- Per-PWM-period sequencer for the FOC datapath.
- On each PWM sync trigger it runs three stages in order: Park transform, d/q PI controllers, inverse Park transform. Each stage is driven with a one-cycle start pulse and completes on its done.
- Commits the inverse-Park alpha/beta result to registered outputs for the SVPWM stage.
- Flags overruns and stage timeouts in sticky error bits.

Parameters:
- D_WIDTH, 32, width of the alpha/beta data words.
- TIMEOUT_CYCLES, 64, maximum cycles allowed per stage after its start pulse (≥2).

Ports:
- clk  in  1  clock
- rstb  in  1  reset
- enable  in  1  sequencer enable
- trig  in  1  PWM-period sync pulse, one cycle
- park_start  out  1  start pulse to Park block
- park_done  in  1  Park block done
- pi_start  out  1  start pulse to PI controllers
- pi_done  in  1  PI controllers done
- ipark_start  out  1  start pulse to inverse Park block
- ipark_done  in  1  inverse Park done
- alpha_in  in  D_WIDTH  signed inverse-Park alpha
- beta_in  in  D_WIDTH  signed inverse-Park beta
- alpha_out  out  D_WIDTH  signed committed alpha
- beta_out  out  D_WIDTH  signed committed beta
- valid  out  1  one-cycle pulse: new alpha_out/beta_out
- busy  out  1  sequence in progress
- overrun  out  1  sticky: trig arrived while busy
- timeout_err  out  1  sticky: a stage exceeded TIMEOUT_CYCLES
- clr_err  in  1  clears overrun and timeout_err

Behaviour:
- Reset: rstb is asynchronous, active-low; clock is clk. While rstb is low, all outputs are 0, state is IDLE and the timeout counter is 0.
- All outputs are registered.
- States:
  - IDLE: sequencer waits for a trigger.
  - PARK, PI, IPARK: sequencer waits for the current stage's done.
  - COMMIT: sequencer writes the result.
- IDLE: trig=1 with enable=1 sampled at edge -> park_start=1 for exactly the next cycle, busy=1, go to PARK. trig with enable=0 is ignored.
- Each wait state:
  - Counter clears on entry.
  - The stage's done is level-sampled only from the cycle after its start pulse.
  - done seen -> next stage's start pulse in the following cycle (PARK->PI->IPARK).
  - Other stages' done inputs are ignored.
- IPARK: when ipark_done is seen, alpha_in/beta_in are captured at that same edge. Next cycle: alpha_out/beta_out are updated, valid=1 for one cycle, busy=0, state returns to IDLE (via COMMIT).
- Latency with every block asserting done 2 cycles after its start (trig in cycle 0):
  - park_start in cycle 1, pi_start in cycle 4, ipark_start in cycle 7.
  - valid in cycle 10.
- Timeout:
  - If done has not been seen by cycle start+TIMEOUT_CYCLES, timeout_err=1 from cycle start+TIMEOUT_CYCLES+1.
  - State goes to IDLE, busy=0, no commit; alpha_out/beta_out hold.
- Overrun: trig while busy=1 sets overrun; the trigger is dropped and the current sequence continues.
- enable deasserted mid-sequence: abort to IDLE next cycle, busy=0, no commit, no error flag, outputs hold.
- trig on the same edge the sequence returns to IDLE (valid cycle): counts as busy, so it sets overrun.
- clr_err clears both sticky flags. A simultaneous set and clear on the same edge: set wins.
- Start outputs are never high for more than one consecutive cycle. At most one start output is high at a time.
- alpha_out/beta_out change only on valid.

Optional Feature:
- Macro: FOC_SEQ_LATENCY_EN.
- Defined: adds output last_latency [15:0]. It holds the cycle count from the trig edge to the valid cycle of the most recent committed sequence (10 in the latency example above). It saturates at 16'hFFFF, resets to 0, and updates only on valid.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Nominal sequence: enable=1, stage models give done 2 cycles after start, alpha_in=-2, beta_in=4096, trig in cycle 0 -> park/pi/ipark_start in cycles 1/4/7, valid in cycle 10, alpha_out=-2, beta_out=4096, busy high for cycles 1-9.
- Timeout: TIMEOUT_CYCLES=8, park_done held 0, trig in cycle 0 -> timeout_err=1 in cycle 10, busy=0, no pi_start, valid never asserted, alpha_out unchanged.
- Overrun: second trig in cycle 5 of the nominal sequence -> overrun=1 from cycle 6, first sequence still produces valid in cycle 10, no second sequence. Then clr_err pulse -> overrun=0.
- Enable abort: drop enable in cycle 5 -> busy=0 in cycle 6, ipark_start never asserted, no error, outputs hold previous values.
- Reset mid-sequence: rstb low in cycle 6 -> all outputs 0 immediately (asynchronous). After release, a new trig gives a nominal sequence with correct timing.
- Spurious done: pi_done and ipark_done pulsed while in PARK -> ignored. Sequence timing still matches the nominal case. With FOC_SEQ_LATENCY_EN defined, last_latency=10.
